// File: rtl/hzd_byp_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard/bypass controller: register-file
// address width, the zero register and the per-stage instruction record.
package hzd_byp_ctrl_pkg;

    localparam int RF_AW = 4;
    localparam logic [RF_AW-1:0] ZERO_REG = '0;

    localparam int REC_DST_W = RF_AW;
    localparam int REC_W     = REC_DST_W + 2;

    typedef struct packed {
        logic [REC_DST_W-1:0] dst;
        logic                 we;
        logic                 ld;
    } stage_rec_t;

    localparam stage_rec_t REC_NOP = '0;

    // A record only forwards when it really writes a non-zero register.
    function automatic logic rec_hit(input stage_rec_t r, input logic [RF_AW-1:0] addr);
        return r.we && (r.dst != ZERO_REG) && (r.dst == addr);
    endfunction

endpackage

// File: rtl/hzd_stage_rec.sv
// One pipeline-stage record {dst, we, ld}: hold has priority over clear,
// clear inserts a bubble, otherwise the record loads the upstream stage.
module hzd_stage_rec
    import hzd_byp_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic       clr,
    input  stage_rec_t d,
    output stage_rec_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= REC_NOP;
        end else if (!hold) begin
            q <= clr ? REC_NOP : d;
        end
    end

endmodule

// File: rtl/hzd_byp_ctrl.sv
// ID-stage hazard and bypass controller: registered EX/DM bypass selects,
// load-use bubble insertion, flush/stall control and a stall-cycle counter.
module hzd_byp_ctrl
    import hzd_byp_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RF_AW-1:0] p0_addr_ID,
    input  logic [RF_AW-1:0] p1_addr_ID,
    input  logic             re0_ID,
    input  logic             re1_ID,
    input  logic [RF_AW-1:0] dst_addr_ID,
    input  logic             rf_we_ID,
    input  logic             mem_re_ID,
    input  logic             flow_change_ID_EX,
    input  logic             stall_ext,
    output logic             byp0_EX,
    output logic             byp0_DM,
    output logic             byp1_EX,
    output logic             byp1_DM,
    output logic             stall_IF_ID,
    output logic             stall_ID_EX,
    output logic             stall_EX_DM,
    output logic             stall_DM_WB,
    output logic             bubble_ID_EX,
    output logic [CNT_W-1:0] stall_cnt
);

    stage_rec_t ex_rec;
    stage_rec_t dm_rec;
    stage_rec_t id_rec;

    logic luh;
    logic kill;
    logic n0_ex, n0_dm, n1_ex, n1_dm;

    assign id_rec = '{dst: dst_addr_ID, we: rf_we_ID, ld: mem_re_ID};

    assign luh = ex_rec.ld && ex_rec.we && (ex_rec.dst != ZERO_REG) &&
                 ((re0_ID && (p0_addr_ID == ex_rec.dst)) ||
                  (re1_ID && (p1_addr_ID == ex_rec.dst)));

    // A flush kills the ID instruction, so a pending load-use is moot.
    assign kill = flow_change_ID_EX || luh;

    assign n0_ex = re0_ID && rec_hit(ex_rec, p0_addr_ID) && !ex_rec.ld;
    assign n0_dm = re0_ID && rec_hit(dm_rec, p0_addr_ID) && !n0_ex;
    assign n1_ex = re1_ID && rec_hit(ex_rec, p1_addr_ID) && !ex_rec.ld;
    assign n1_dm = re1_ID && rec_hit(dm_rec, p1_addr_ID) && !n1_ex;

    hzd_stage_rec u_ex_rec (
        .clk  (clk),
        .rst  (rst),
        .hold (stall_ext),
        .clr  (kill),
        .d    (id_rec),
        .q    (ex_rec)
    );

    hzd_stage_rec u_dm_rec (
        .clk  (clk),
        .rst  (rst),
        .hold (stall_ext),
        .clr  (1'b0),
        .d    (ex_rec),
        .q    (dm_rec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp0_EX <= 1'b0;
            byp0_DM <= 1'b0;
            byp1_EX <= 1'b0;
            byp1_DM <= 1'b0;
        end else if (!stall_ext) begin
            byp0_EX <= !kill && n0_ex;
            byp0_DM <= !kill && n0_dm;
            byp1_EX <= !kill && n1_ex;
            byp1_DM <= !kill && n1_dm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!stall_ext && luh && !flow_change_ID_EX && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Gated by rst so every control reads idle while reset is asserted.
    assign stall_IF_ID  = !rst && (stall_ext || (luh && !flow_change_ID_EX));
    assign stall_ID_EX  = !rst && stall_ext;
    assign stall_EX_DM  = !rst && stall_ext;
    assign stall_DM_WB  = !rst && stall_ext;
    assign bubble_ID_EX = !rst && !stall_ext && kill;

endmodule

// File: tb/tb_hzd_byp_ctrl.sv
// Self-checking bench for hzd_byp_ctrl: directed scenarios plus random traffic
// against an instruction-history reference model.
module tb_hzd_byp_ctrl;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    p0_addr_ID = '0, p1_addr_ID = '0, dst_addr_ID = '0;
    logic          re0_ID = 0, re1_ID = 0, rf_we_ID = 0, mem_re_ID = 0;
    logic          flow_change_ID_EX = 0, stall_ext = 0;
    logic          byp0_EX, byp0_DM, byp1_EX, byp1_DM;
    logic          stall_IF_ID, stall_ID_EX, stall_EX_DM, stall_DM_WB, bubble_ID_EX;
    logic [CW-1:0] stall_cnt;
    logic [3:0]    obs_byp;
    logic [2:0]    obs_oth;

    always #5 clk = ~clk;

    hzd_byp_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .p0_addr_ID(p0_addr_ID), .p1_addr_ID(p1_addr_ID),
        .re0_ID(re0_ID), .re1_ID(re1_ID),
        .dst_addr_ID(dst_addr_ID), .rf_we_ID(rf_we_ID), .mem_re_ID(mem_re_ID),
        .flow_change_ID_EX(flow_change_ID_EX), .stall_ext(stall_ext),
        .byp0_EX(byp0_EX), .byp0_DM(byp0_DM), .byp1_EX(byp1_EX), .byp1_DM(byp1_DM),
        .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX),
        .stall_EX_DM(stall_EX_DM), .stall_DM_WB(stall_DM_WB),
        .bubble_ID_EX(bubble_ID_EX), .stall_cnt(stall_cnt)
    );

    assign obs_byp = {byp0_EX, byp0_DM, byp1_EX, byp1_DM};
    assign obs_oth = {stall_ID_EX, stall_EX_DM, stall_DM_WB};

    int total = 0;
    int bad   = 0;

    // Reference model: hist[0] is the instruction now in EX, hist[1] in DM.
    typedef struct {
        logic [3:0] dst;
        bit         we;
        bit         ld;
    } instr_t;

    instr_t     hist[$];
    logic [3:0] e_byp;
    int         e_cnt;
    bit         e_stall_if, e_bubble, e_stall_oth;

    function automatic instr_t nop();
        instr_t n;
        n.dst = '0; n.we = 0; n.ld = 0;
        return n;
    endfunction

    function automatic int producer(logic [3:0] a);
        for (int i = 0; i < 2; i++)
            if (hist[i].we && hist[i].dst != 0 && hist[i].dst == a) return i;
        return -1;
    endfunction

    function automatic bit model_luh();
        instr_t e = hist[0];
        return e.ld && e.we && e.dst != 0 &&
               ((re0_ID && p0_addr_ID == e.dst) || (re1_ID && p1_addr_ID == e.dst));
    endfunction

    task automatic model_reset();
        hist.delete();
        hist.push_back(nop());
        hist.push_back(nop());
        e_byp = '0;
        e_cnt = 0;
    endtask

    task automatic model_comb();
        bit l = model_luh();
        e_stall_if  = stall_ext || (l && !flow_change_ID_EX);
        e_bubble    = !stall_ext && (flow_change_ID_EX || l);
        e_stall_oth = stall_ext;
    endtask

    task automatic model_clock();
        bit l;
        int s0, s1;
        instr_t n;
        if (stall_ext) return;
        l = model_luh();
        if (flow_change_ID_EX || l) begin
            e_byp = '0;
            if (l && !flow_change_ID_EX && e_cnt < CMAX) e_cnt++;
            hist.push_front(nop());
        end else begin
            s0 = producer(p0_addr_ID);
            s1 = producer(p1_addr_ID);
            e_byp[3] = re0_ID && s0 == 0 && !hist[0].ld;
            e_byp[2] = re0_ID && s0 == 1;
            e_byp[1] = re1_ID && s1 == 0 && !hist[0].ld;
            e_byp[0] = re1_ID && s1 == 1;
            n.dst = dst_addr_ID; n.we = rf_we_ID; n.ld = mem_re_ID;
            hist.push_front(n);
        end
        void'(hist.pop_back());
    endtask

    task automatic drive(input logic [3:0] p0, input bit r0, input logic [3:0] p1, input bit r1,
                         input logic [3:0] d, input bit we, input bit ld, input bit fl, input bit sx);
        @(negedge clk);
        p0_addr_ID = p0; re0_ID = r0; p1_addr_ID = p1; re1_ID = r1;
        dst_addr_ID = d; rf_we_ID = we; mem_re_ID = ld;
        flow_change_ID_EX = fl; stall_ext = sx;
        #1;
        model_comb();
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic test_reset();
        stall_ext = 1; re0_ID = 1; re1_ID = 1;
        #12;
        total++;
        if ({obs_byp, stall_IF_ID, obs_oth, bubble_ID_EX, stall_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got byp=%b sif=%b oth=%b bub=%b cnt=%0d want all 0",
                     obs_byp, stall_IF_ID, obs_oth, bubble_ID_EX, stall_cnt);
        end
        @(negedge clk);
        stall_ext = 0; re0_ID = 0; re1_ID = 0;
        rst = 0;
        model_reset();
    endtask

    task automatic test_ex_bypass();
        drive(4'd0, 0, 4'd0, 0, 4'd3, 1, 0, 0, 0);
        tick();
        drive(4'd3, 1, 4'd4, 1, 4'd6, 1, 0, 0, 0);
        total++;
        if ({stall_IF_ID, bubble_ID_EX} !== 2'b00 || {stall_IF_ID, bubble_ID_EX} !== {e_stall_if, e_bubble}) begin
            bad++;
            $display("FAIL ex_byp_nostall: got %b want 00", {stall_IF_ID, bubble_ID_EX});
        end
        tick();
        total++;
        if (obs_byp !== 4'b1000 || obs_byp !== e_byp) begin
            bad++;
            $display("FAIL ex_byp_sel: got %b want 1000 (model %b)", obs_byp, e_byp);
        end
    endtask

    task automatic test_dm_bypass();
        drive(4'd0, 0, 4'd0, 0, 4'd3, 1, 0, 0, 0);
        tick();
        drive(4'd0, 0, 4'd0, 0, 4'd7, 1, 0, 0, 0);
        tick();
        drive(4'd0, 0, 4'd3, 1, 4'd8, 1, 0, 0, 0);
        tick();
        total++;
        if (obs_byp !== 4'b0001 || obs_byp !== e_byp) begin
            bad++;
            $display("FAIL dm_byp_sel: got %b want 0001 (model %b)", obs_byp, e_byp);
        end
    endtask

    task automatic test_load_use();
        int c0 = e_cnt;
        drive(4'd0, 0, 4'd0, 0, 4'd5, 1, 1, 0, 0);
        tick();
        drive(4'd5, 1, 4'd0, 0, 4'd8, 1, 0, 0, 0);
        total++;
        if ({stall_IF_ID, bubble_ID_EX, obs_oth} !== 5'b11000 || {stall_IF_ID, bubble_ID_EX} !== {e_stall_if, e_bubble}) begin
            bad++;
            $display("FAIL luh_stall: got sif/bub/oth=%b want 11000", {stall_IF_ID, bubble_ID_EX, obs_oth});
        end
        tick();
        total++;
        if (stall_cnt !== CW'(c0 + 1) || stall_cnt !== CW'(e_cnt) || obs_byp !== 4'b0000) begin
            bad++;
            $display("FAIL luh_count: got cnt=%0d byp=%b want cnt=%0d byp=0000", stall_cnt, obs_byp, c0 + 1);
        end
        drive(4'd5, 1, 4'd0, 0, 4'd8, 1, 0, 0, 0);
        total++;
        if ({stall_IF_ID, bubble_ID_EX} !== 2'b00) begin
            bad++;
            $display("FAIL luh_one_cycle: got %b want 00", {stall_IF_ID, bubble_ID_EX});
        end
        tick();
        total++;
        if (obs_byp !== 4'b0100 || obs_byp !== e_byp) begin
            bad++;
            $display("FAIL luh_dm_byp: got %b want 0100", obs_byp);
        end
    endtask

    task automatic test_r0();
        drive(4'd0, 0, 4'd0, 0, 4'd0, 1, 0, 0, 0);
        tick();
        drive(4'd0, 1, 4'd0, 1, 4'd9, 1, 0, 0, 0);
        tick();
        total++;
        if (obs_byp !== 4'b0000 || obs_byp !== e_byp) begin
            bad++;
            $display("FAIL r0_no_byp: got %b want 0000", obs_byp);
        end
    endtask

    task automatic test_flush_luh();
        int c0 = e_cnt;
        drive(4'd0, 0, 4'd0, 0, 4'd5, 1, 1, 0, 0);
        tick();
        drive(4'd5, 1, 4'd0, 0, 4'd8, 1, 0, 1, 0);
        total++;
        if ({stall_IF_ID, bubble_ID_EX} !== 2'b01 || {stall_IF_ID, bubble_ID_EX} !== {e_stall_if, e_bubble}) begin
            bad++;
            $display("FAIL flush_ctrl: got sif/bub=%b want 01", {stall_IF_ID, bubble_ID_EX});
        end
        tick();
        total++;
        if (stall_cnt !== CW'(c0) || obs_byp !== 4'b0000) begin
            bad++;
            $display("FAIL flush_state: got cnt=%0d byp=%b want cnt=%0d byp=0000", stall_cnt, obs_byp, c0);
        end
        drive(4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_stall_ext();
        drive(4'd0, 0, 4'd0, 0, 4'd3, 1, 0, 0, 0);
        tick();
        drive(4'd3, 1, 4'd0, 0, 4'd6, 1, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(4'd0, 0, 4'd6, 1, 4'd10, 1, 0, 0, 1);
            total++;
            if ({stall_IF_ID, obs_oth, bubble_ID_EX} !== 5'b11110) begin
                bad++;
                $display("FAIL ext_ctrl[%0d]: got %b want 11110", i, {stall_IF_ID, obs_oth, bubble_ID_EX});
            end
            tick();
            total++;
            if (obs_byp !== 4'b1000 || obs_byp !== e_byp) begin
                bad++;
                $display("FAIL ext_hold[%0d]: got %b want 1000", i, obs_byp);
            end
        end
        drive(4'd0, 0, 4'd6, 1, 4'd10, 1, 0, 0, 0);
        tick();
        total++;
        if (obs_byp !== 4'b0010 || obs_byp !== e_byp) begin
            bad++;
            $display("FAIL ext_release: got %b want 0010", obs_byp);
        end
    endtask

    task automatic test_reset_mid_stall();
        drive(4'd0, 0, 4'd10, 1, 4'd11, 1, 0, 0, 1);
        #2;
        rst = 1;
        #1;
        total++;
        if ({obs_byp, stall_IF_ID, obs_oth, bubble_ID_EX, stall_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_mid_stall: got byp=%b sif=%b oth=%b bub=%b cnt=%0d want all 0",
                     obs_byp, stall_IF_ID, obs_oth, bubble_ID_EX, stall_cnt);
        end
        @(negedge clk);
        rst = 0;
        stall_ext = 0;
        model_reset();
        drive(4'd3, 1, 4'd6, 1, 4'd0, 0, 0, 0, 0);
        tick();
        total++;
        if (obs_byp !== 4'b0000 || stall_cnt !== '0) begin
            bad++;
            $display("FAIL post_reset: got byp=%b cnt=%0d want 0000/0", obs_byp, stall_cnt);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < CMAX + 4; i++) begin
            drive(4'd0, 0, 4'd0, 0, 4'd5, 1, 1, 0, 0);
            tick();
            drive(4'd0, 0, 4'd5, 1, 4'd2, 1, 0, 0, 0);
            tick();
            total++;
            if (stall_cnt !== CW'(e_cnt)) begin
                bad++;
                $display("FAIL sat_step[%0d]: got %0d want %0d", i, stall_cnt, e_cnt);
            end
        end
        total++;
        if (stall_cnt !== CW'(CMAX)) begin
            bad++;
            $display("FAIL sat_final: got %0d want %0d", stall_cnt, CMAX);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(4'($urandom_range(0, 3)), ($urandom % 2) == 0,
                  4'($urandom_range(0, 3)), ($urandom % 2) == 0,
                  4'($urandom_range(0, 3)), ($urandom % 4) != 0, ($urandom % 3) == 0,
                  ($urandom % 8) == 0, ($urandom % 6) == 0);
            total++;
            if ({stall_IF_ID, bubble_ID_EX, obs_oth} !== {e_stall_if, e_bubble, {3{e_stall_oth}}}) begin
                bad++;
                $display("FAIL rand_ctrl[%0d]: got %b want %b", i,
                         {stall_IF_ID, bubble_ID_EX, obs_oth}, {e_stall_if, e_bubble, {3{e_stall_oth}}});
            end
            tick();
            total++;
            if (obs_byp !== e_byp || stall_cnt !== CW'(e_cnt)) begin
                bad++;
                $display("FAIL rand_state[%0d]: got byp=%b cnt=%0d want byp=%b cnt=%0d",
                         i, obs_byp, stall_cnt, e_byp, e_cnt);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ex_bypass();
        test_dm_bypass();
        test_load_use();
        test_r0();
        test_flush_luh();
        test_stall_ext();
        test_reset_mid_stall();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hzd_byp_ctrl.md
Name: hzd_byp_ctrl

Overview:
ID-stage hazard and bypass controller for the 16-bit 5-stage pipeline. It tracks the destination register and load status of the instructions in the EX and DM stages. From these it generates registered bypass selects (byp0/1_EX, byp0/1_DM) for the EX-stage source bypass muxes, plus the pipeline stall and flush controls. It also resolves load-use hazards by inserting a single bubble, and keeps a saturating stall-cycle counter for debug.

Parameters:
RF_AW, 4, register-file address width (R0 hard-wired zero)
CNT_W, 16, width of stall performance counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
p0_addr_ID  in  RF_AW  src0 register address of instruction in ID
p1_addr_ID  in  RF_AW  src1 register address of instruction in ID
re0_ID  in  1  instruction in ID reads port 0
re1_ID  in  1  instruction in ID reads port 1
dst_addr_ID  in  RF_AW  destination register of instruction in ID
rf_we_ID  in  1  instruction in ID writes RF
mem_re_ID  in  1  instruction in ID is a load (LW)
flow_change_ID_EX  in  1  taken branch/jump resolved in EX; kill IF_ID and ID
stall_ext  in  1  external freeze (DM wait, HLT); holds every stage
byp0_EX  out  1  src0 takes dst_EX_DM
byp0_DM  out  1  src0 takes dst_DM_WB
byp1_EX  out  1  src1 takes dst_EX_DM
byp1_DM  out  1  src1 takes dst_DM_WB
stall_IF_ID  out  1  hold PC and IF_ID
stall_ID_EX  out  1  hold ID_EX
stall_EX_DM  out  1  hold EX_DM
stall_DM_WB  out  1  hold DM_WB
bubble_ID_EX  out  1  load NOP controls into ID_EX this cycle
stall_cnt  out  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Internal stage records: EX record {dst, we, ld}, DM record {dst, we}. Records, byp outputs and stall_cnt are flops. All other outputs are combinational.
- Reset (async, rst=1): all records cleared (we=0, ld=0), all byp outputs=0, stall_cnt=0. Outputs during reset: stall_*=0, bubble_ID_EX=0.
- Effective write: a record matches only if we=1 and dst!=0. Writes to R0 never bypass.
- Load-use hazard (combinational): luh = EX.ld & EX.we & EX.dst!=0 & ((re0_ID & p0_addr_ID==EX.dst) | (re1_ID & p1_addr_ID==EX.dst)).
- Bypass compute for instruction in ID, when neither a hazard nor a stall applies:
  - n0_EX = re0_ID & match(EX, p0_addr_ID); n0_DM = re0_ID & match(DM, p0_addr_ID) & !n0_EX. Same for port 1. EX has priority.
  - Loads are never EX-bypassed (luh covers that case).
  - WB-stage writes are not bypassed; the RF is write-through.
- Each cycle, when stall_ext=0 and no flush:
  - DM record <= EX record.
  - If luh: EX record <= cleared (bubble), byp outputs <= 0, stall_IF_ID=1, bubble_ID_EX=1, stall_cnt increments, saturating at all-ones.
  - Else: EX record <= {dst_addr_ID, rf_we_ID, mem_re_ID}, byp outputs <= computed values.
- After a load-use bubble, the load sits in DM. On the next cycle the consumer computes byp_DM=1, so it takes the load data from dst_DM_WB in EX. Net latency is exactly one extra cycle.
- flow_change_ID_EX=1 (and stall_ext=0):
  - EX record <= cleared, byp outputs <= 0, bubble_ID_EX=1.
  - luh is ignored because the ID instruction is killed.
  - DM record advances normally; the branch itself continues.
- stall_ext=1 has priority over everything:
  - All records, byp outputs and stall_cnt hold.
  - stall_IF_ID = stall_ID_EX = stall_EX_DM = stall_DM_WB = 1, bubble_ID_EX=0.
- stall_ID_EX, stall_EX_DM and stall_DM_WB are 1 only under stall_ext.
- Simultaneous luh + flush: flush wins, with no stall and no count increment.
- Reset asserted mid-stall: returns to the reset state immediately; no pending bubble is retained.

Decomposition:
- Shared package/include (alongside common_params.inc): RF_AW, ZERO_REG constant, stage-record field widths.
- One natural sub-module, hzd_stage_rec: a clearable/holdable {dst, we, ld} register. It is instantiated twice (EX and DM records).

Test Plan:
1. ADD R3 in ID, then SUB reading R3 on p0 the next cycle -> byp0_EX=1, byp0_DM=0 in the SUB's EX cycle; no stall.
2. ADD R3, unrelated instruction, then SUB reading R3 on p1 -> byp1_DM=1, byp1_EX=0.
3. LW R5, then ADD reading R5 on p0:
   - stall_IF_ID=1 and bubble_ID_EX=1 for exactly one cycle; stall_cnt 0->1.
   - Next cycle byp0_DM=1.
4. Write to R0 followed by a read of R0 -> all byp outputs=0.
5. LW R5 + dependent ADD while flow_change_ID_EX=1 the same cycle -> no stall_IF_ID, bubble_ID_EX=1, stall_cnt unchanged, byp outputs 0.
6. stall_ext held 3 cycles during case 1 -> records and byp outputs frozen, all stall_*=1. After release, byp0_EX=1 as in case 1.
   - Then pulse rst mid-stall -> every output and stall_cnt reads 0 asynchronously.
